// File: rtl/seq_serializer_if.sv
// Word-load / bit-stream bundle between an upstream word source and seq_serializer.
// The master side drives words and pacing. The slave side returns the serial bit and its status.
interface seq_serializer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] din;
    logic             load_valid;
    logic             load_ready;
    logic             shift_en;
    logic             xout;
    logic             xout_valid;
    logic             busy;
    logic             done;

    modport master (
        output din, load_valid, shift_en,
        input  load_ready, xout, xout_valid, busy, done
    );

    modport slave (
        input  din, load_valid, shift_en,
        output load_ready, xout, xout_valid, busy, done
    );
endinterface

// File: rtl/seq_serializer.sv
// Parallel-in serial-out shifter feeding the sequence detectors, one bit per shift_en edge.
// Latency: first bit on xout the cycle after the accepting edge; back-to-back words leave no gap.
// Backpressure: load_ready only in IDLE or on the consuming edge of the last bit; shift_en=0 freezes the stream.
module seq_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    seq_serializer_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;
    logic [WIDTH-1:0] shreg_shifted;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;
    logic             last_bit;
    logic             advance;
    logic             ready;
    logic             accept;

    assign last_bit = (state_q == SHIFT) && (cnt_q == CW'(WIDTH - 1));
    assign advance  = last_bit && bus.shift_en;
    assign ready    = (state_q == IDLE) || advance;
    assign accept   = ready && bus.load_valid;

    // Shift toward the output end so the next bit always sits at the tap.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign shreg_shifted = {shreg_q[WIDTH-2:0], 1'b0};
        end else begin : g_lsb_first
            assign shreg_shifted = {1'b0, shreg_q[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.load_valid) state_d = SHIFT;
            SHIFT:   if (advance && !bus.load_valid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Finishing a word without a follow-on clears the register so IDLE holds zeros.
    always_comb begin
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        if (accept) begin
            shreg_d = bus.din;
            cnt_d   = '0;
        end else if (advance) begin
            shreg_d = '0;
            cnt_d   = '0;
        end else if ((state_q == SHIFT) && bus.shift_en) begin
            shreg_d = shreg_shifted;
            cnt_d   = cnt_q + CW'(1);
        end
    end

    always_comb begin
        bus.load_ready = ready;
        bus.done       = advance;
        bus.xout_valid = (state_q == SHIFT);
        bus.busy       = (state_q == SHIFT);
        bus.xout       = 1'b0;
        if (state_q == SHIFT) begin
            bus.xout = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
        end
    end
endmodule
